// File: rtl/nand_gate_bank.sv
// nand_gate_bank: registered NAND/NOT/AND bank built from two-input NAND cells
module nand2 (
   input  logic x,
   input  logic y,
   output logic z
);
   assign z = ~(x & y);
endmodule

module nand_gate_bank #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [1:0]       op,
   output logic [WIDTH-1:0] y_nand,
   output logic [WIDTH-1:0] y_not,
   output logic [WIDTH-1:0] y_and,
   output logic [WIDTH-1:0] y_sel,
   output logic             out_valid,
   output logic             op_err
);
   logic [WIDTH-1:0] nand_w, not_w, and_w, sel_w;
   for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      nand2 u_nand (.x(a[i]),      .y(b[i]),      .z(nand_w[i]));
      nand2 u_not  (.x(a[i]),      .y(a[i]),      .z(not_w[i]));
      nand2 u_and  (.x(nand_w[i]), .y(nand_w[i]), .z(and_w[i]));
   end
   always_comb begin
      sel_w = op == 2'b00 ? nand_w :
              op == 2'b01 ? not_w  :
              op == 2'b10 ? and_w  : '0;
   end
   // Results hold between captures; only reset clears them.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         y_nand    <= '0;
         y_not     <= '0;
         y_and     <= '0;
         y_sel     <= '0;
         out_valid <= 1'b0;
         op_err    <= 1'b0;
      end else begin
         out_valid <= in_valid;
         if (in_valid) begin
            y_nand <= nand_w;
            y_not  <= not_w;
            y_and  <= and_w;
            y_sel  <= sel_w;
            op_err <= op == 2'b11;
         end
      end
   end
endmodule

// File: tb/tb_nand_gate_bank.sv
// tb_nand_gate_bank: scoreboard bench for nand_gate_bank at WIDTH=16
module tb_nand_gate_bank;
   typedef struct packed {
      logic [15:0] n;
      logic [15:0] nt;
      logic [15:0] an;
      logic [15:0] sel;
      logic        err;
      logic        v;
   } exp_t;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic [15:0] a = '0, b = '0;
   logic [1:0]  op = '0;
   logic [15:0] y_nand, y_not, y_and, y_sel;
   logic        out_valid, op_err;
   logic [65:0] obs;
   exp_t        q[$];
   exp_t        last = '0;
   exp_t        e;
   int          tests = 0;
   int          fails = 0;
   nand_gate_bank #(.WIDTH(16)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .a(a), .b(b), .op(op),
      .y_nand(y_nand), .y_not(y_not), .y_and(y_and), .y_sel(y_sel),
      .out_valid(out_valid), .op_err(op_err)
   );
   assign obs = {y_nand, y_not, y_and, y_sel, op_err, out_valid};
   always #5 clk = ~clk;
   task automatic drive(input logic [15:0] da, input logic [15:0] db, input logic [1:0] dop);
      exp_t x;
      a = da;
      b = db;
      op = dop;
      in_valid = 1'b1;
      x.n   = ~(da & db);
      x.nt  = ~da;
      x.an  = da & db;
      x.sel = dop == 2'd0 ? x.n : dop == 2'd1 ? x.nt : dop == 2'd2 ? x.an : 16'h0;
      x.err = dop == 2'd3;
      x.v   = 1'b1;
      last = x;
      q.push_back(x);
   endtask
   task automatic idle();
      exp_t x;
      in_valid = 1'b0;
      a = 16'hDEAD;
      b = 16'hBEEF;
      x = last;
      x.v = 1'b0;
      q.push_back(x);
   endtask
   task automatic test_reset();
      @(posedge clk);
      #1;
      tests++;
      if (obs !== 66'h0) begin
         fails++;
         $display("FAIL reset got %h expected %h", obs, 66'h0);
      end
      rst = 1'b0;
   endtask
   task automatic test_truth();
      drive(16'h0000, 16'h0000, 2'd0);
      @(posedge clk); #1;
      drive(16'h0000, 16'h0001, 2'd0);
      e = q.pop_front(); tests++;
      if (obs !== e) begin fails++; $display("FAIL truth00 got %h expected %h", obs, e); end
      @(posedge clk); #1;
      drive(16'h0001, 16'h0000, 2'd0);
      e = q.pop_front(); tests++;
      if (obs !== e) begin fails++; $display("FAIL truth01 got %h expected %h", obs, e); end
      @(posedge clk); #1;
      drive(16'h0001, 16'h0001, 2'd2);
      e = q.pop_front(); tests++;
      if (obs !== e) begin fails++; $display("FAIL truth10 got %h expected %h", obs, e); end
      @(posedge clk); #1;
      idle();
      e = q.pop_front(); tests++;
      if (obs !== e) begin fails++; $display("FAIL truth11 got %h expected %h", obs, e); end
      @(posedge clk); #1;
      e = q.pop_front(); tests++;
      if (obs !== e) begin fails++; $display("FAIL truth_idle got %h expected %h", obs, e); end
   endtask
   task automatic test_pattern_hold();
      drive(16'hF0F0, 16'hFF00, 2'd1);
      @(posedge clk); #1;
      e = q.pop_front(); tests++;
      if (obs !== {16'h0FFF, 16'h0F0F, 16'hF000, 16'h0F0F, 1'b0, 1'b1}) begin
         fails++;
         $display("FAIL pattern got %h expected %h", obs, {16'h0FFF, 16'h0F0F, 16'hF000, 16'h0F0F, 1'b0, 1'b1});
      end
      for (int i = 0; i < 3; i++) begin
         idle();
         @(posedge clk); #1;
         e = q.pop_front(); tests++;
         if (obs !== e) begin fails++; $display("FAIL hold%0d got %h expected %h", i, obs, e); end
      end
   endtask
   task automatic test_op_err();
      drive(16'hFFFF, 16'hFFFF, 2'd3);
      @(posedge clk); #1;
      idle();
      e = q.pop_front(); tests++;
      if (obs !== {16'h0000, 16'h0000, 16'hFFFF, 16'h0000, 1'b1, 1'b1}) begin
         fails++;
         $display("FAIL op_err got %h expected %h", obs, {16'h0000, 16'h0000, 16'hFFFF, 16'h0000, 1'b1, 1'b1});
      end
      @(posedge clk); #1;
      e = q.pop_front(); tests++;
      if (obs !== e) begin fails++; $display("FAIL op_err_hold got %h expected %h", obs, e); end
   endtask
   task automatic test_back_to_back();
      drive(16'(($urandom)), 16'($urandom), 2'($urandom_range(0, 3)));
      for (int i = 0; i < 12; i++) begin
         @(posedge clk); #1;
         if (i < 11) drive(16'($urandom), 16'($urandom), 2'($urandom_range(0, 3)));
         else idle();
         e = q.pop_front(); tests++;
         if (obs !== e) begin fails++; $display("FAIL b2b%0d got %h expected %h", i, obs, e); end
      end
      @(posedge clk); #1;
      e = q.pop_front(); tests++;
      if (obs !== e) begin fails++; $display("FAIL b2b_end got %h expected %h", obs, e); end
   endtask
   task automatic test_async_reset();
      drive(16'h1234, 16'h5678, 2'd0);
      @(posedge clk); #1;
      drive(16'hA5A5, 16'h0FF0, 2'd2);
      #2;
      rst = 1'b1;
      #1;
      tests++;
      if (obs !== 66'h0) begin fails++; $display("FAIL async_rst got %h expected %h", obs, 66'h0); end
      @(posedge clk); #1;
      tests++;
      if (obs !== 66'h0) begin fails++; $display("FAIL rst_discard got %h expected %h", obs, 66'h0); end
      q.delete();
      last = '0;
      in_valid = 1'b0;
      #2;
      rst = 1'b0;
      @(posedge clk); #1;
      drive(16'h0001, 16'h0001, 2'd0);
      @(posedge clk); #1;
      idle();
      e = q.pop_front(); tests++;
      if (obs !== {16'hFFFE, 16'hFFFE, 16'h0001, 16'hFFFE, 1'b0, 1'b1}) begin
         fails++;
         $display("FAIL post_rst got %h expected %h", obs, {16'hFFFE, 16'hFFFE, 16'h0001, 16'hFFFE, 1'b0, 1'b1});
      end
      @(posedge clk); #1;
      e = q.pop_front(); tests++;
      if (obs !== e) begin fails++; $display("FAIL post_rst_idle got %h expected %h", obs, e); end
   endtask
   initial begin
      test_reset();
      test_truth();
      test_pattern_hold();
      test_op_err();
      test_back_to_back();
      test_async_reset();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
